// File: rtl/mackerel_bus_if.sv
// 68000 bus-cycle handshake bundle between CPU/decoder and the bus controller.
interface mackerel_bus_if;
  logic AS;         // address strobe, active-low
  logic ROMEN;      // ROM select, active-low
  logic RAMEN;      // RAM select, active-low
  logic MFPEN;      // MFP select, active-low
  logic IACK;       // interrupt-acknowledge cycle, active-low
  logic DTACK_MFP;  // DTACK from MFP, active-low
  logic DTACK;      // DTACK to CPU, active-low
  logic BERR;       // bus error to CPU, active-low
  logic VPA;        // autovector request to CPU, active-low
  logic BUSY;       // cycle in progress

  modport master (
    output AS, ROMEN, RAMEN, MFPEN, IACK, DTACK_MFP,
    input  DTACK, BERR, VPA, BUSY
  );

  modport slave (
    input  AS, ROMEN, RAMEN, MFPEN, IACK, DTACK_MFP,
    output DTACK, BERR, VPA, BUSY
  );
endinterface

// File: rtl/mackerel_bus_ctrl.sv
// Bus-cycle controller: per-device wait states, DTACK/VPA/BERR generation.
// All outputs come straight from flops loaded with the next-state decode.
module mackerel_bus_ctrl #(
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 0,
  parameter int AV_WAIT  = 16,
  parameter int TIMEOUT  = 64
) (
  input logic           CLK,
  input logic           RST,
  mackerel_bus_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_AVEC, S_BERR} state_t;
  typedef enum logic [2:0] {C_NONE, C_RAM, C_ROM, C_MFP, C_IACK} cls_t;

  localparam logic [3:0] ROM_W   = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W   = 4'(RAM_WAIT);
  localparam logic [9:0] AV_LAST = 10'(AV_WAIT - 1);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t     state, nxt;
  cls_t       cls, cls_n;
  logic [3:0] wcnt, wcnt_n;
  logic [9:0] tcnt, tcnt_n;
  logic       go_ack, go_av;
  logic       dtack_q, berr_q, vpa_q, busy_q;

  // Next-state, class latch and counter update.
  always_comb begin
    nxt    = state;
    cls_n  = cls;
    wcnt_n = wcnt;
    tcnt_n = tcnt;
    go_ack = 1'b0;
    go_av  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.AS) begin
          nxt    = S_WAIT;
          tcnt_n = '0;
          wcnt_n = '0;
          if (!bus.IACK)       cls_n = C_IACK;
          else if (!bus.MFPEN) cls_n = C_MFP;
          else if (!bus.ROMEN) begin
            cls_n  = C_ROM;
            wcnt_n = ROM_W;
          end else if (!bus.RAMEN) begin
            cls_n  = C_RAM;
            wcnt_n = RAM_W;
          end else               cls_n = C_NONE;
        end
      end
      S_WAIT: begin
        if (bus.AS) begin
          nxt = S_IDLE;
        end else begin
          case (cls)
            C_ROM, C_RAM: begin
              if (wcnt == '0) go_ack = 1'b1;
              else            wcnt_n = wcnt - 4'd1;
            end
            C_MFP:  go_ack = !bus.DTACK_MFP;
            C_IACK: begin
              if (!bus.DTACK_MFP)     go_ack = 1'b1;
              else if (tcnt == AV_LAST) go_av = 1'b1;
            end
            default: ;
          endcase
          // Ack/autovector take precedence over a coincident timeout.
          if (go_ack)               nxt = S_ACK;
          else if (go_av)           nxt = S_AVEC;
          else if (tcnt == TO_LAST) nxt = S_BERR;
          else                      tcnt_n = tcnt + 10'd1;
        end
      end
      S_ACK, S_AVEC, S_BERR: begin
        if (bus.AS) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= S_IDLE;
      cls     <= C_NONE;
      wcnt    <= '0;
      tcnt    <= '0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
      vpa_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= nxt;
      cls     <= cls_n;
      wcnt    <= wcnt_n;
      tcnt    <= tcnt_n;
      dtack_q <= (nxt != S_ACK);
      berr_q  <= (nxt != S_BERR);
      vpa_q   <= (nxt != S_AVEC);
      busy_q  <= (nxt != S_IDLE);
    end
  end

  assign bus.DTACK = dtack_q;
  assign bus.BERR  = berr_q;
  assign bus.VPA   = vpa_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_mackerel_bus_ctrl.sv
// Scoreboard bench: stimulus pushes expected output-vector changes
// {BUSY,DTACK,VPA,BERR} with the edge they must appear on; a monitor pops
// and compares every change the controller actually makes.
module tb_mackerel_bus_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;

  mackerel_bus_if bus();

  mackerel_bus_ctrl #(.ROM_WAIT(2), .RAM_WAIT(0), .AV_WAIT(16), .TIMEOUT(64)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] vec;
    int         at;
  } exp_t;

  localparam logic [3:0] V_IDLE  = 4'b0111;
  localparam logic [3:0] V_BUSY  = 4'b1111;
  localparam logic [3:0] V_DTACK = 4'b1011;
  localparam logic [3:0] V_VPA   = 4'b1101;
  localparam logic [3:0] V_BERR  = 4'b1110;

  exp_t       sb[$];
  int         compared = 0;
  int         mismatched = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev;

  // Monitor: every change of the output vector must match the queue head.
  always @(negedge CLK) begin
    logic [3:0] v;
    exp_t       e;
    v = {bus.BUSY, bus.DTACK, bus.VPA, bus.BERR};
    if (mon_en && v !== prev) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change: got vec=%b at edge %0d, want no change", v, cyc);
      end else begin
        e = sb.pop_front();
        if (v !== e.vec || cyc != e.at) begin
          mismatched++;
          $display("FAIL event: got vec=%b at edge %0d, want vec=%b at edge %0d",
                   v, cyc, e.vec, e.at);
        end
      end
      prev = v;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] vec, input int at);
    exp_t e;
    e.vec = vec;
    e.at  = at;
    sb.push_back(e);
  endtask

  // Every pending expectation must be seen within a few edges.
  task automatic drain(input string name);
    for (int i = 0; i < 4 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_missing: got %0d events outstanding, want 0 (next vec=%b at edge %0d)",
               name, sb.size(), sb[0].vec, sb[0].at);
      sb.delete();
    end
  endtask

  // One bus cycle. Edge numbers are relative to E0 (edge that samples AS low).
  // mfp_at: edge on which DTACK_MFP is first sampled low (-1 = never).
  // rel_at: edge on which AS is first sampled high again.
  // rsp/rsp_at: expected response vector and its edge (rsp_at<0 = none).
  task automatic run_cycle(input logic romen, input logic ramen, input logic mfpen,
                           input logic iack, input int mfp_at, input int rel_at,
                           input logic [3:0] rsp, input int rsp_at);
    int e0;
    e0 = cyc + 1;
    bus.AS = 1'b0;
    bus.ROMEN = romen;
    bus.RAMEN = ramen;
    bus.MFPEN = mfpen;
    bus.IACK  = iack;
    push(V_BUSY, e0);
    if (rsp_at >= 0) push(rsp, e0 + rsp_at);
    push(V_IDLE, e0 + rel_at);
    for (int k = 0; k <= rel_at; k++) begin
      if (k == mfp_at) bus.DTACK_MFP = 1'b0;
      if (k == rel_at) begin
        bus.AS = 1'b1;
        bus.ROMEN = 1'b1;
        bus.RAMEN = 1'b1;
        bus.MFPEN = 1'b1;
        bus.IACK  = 1'b1;
        bus.DTACK_MFP = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    int e0;
    RST = 1'b0;
    bus.AS = 1'b1;
    bus.ROMEN = 1'b1;
    bus.RAMEN = 1'b1;
    bus.MFPEN = 1'b1;
    bus.IACK  = 1'b1;
    bus.DTACK_MFP = 1'b1;
    repeat (3) tick();

    compared++;
    if ({bus.BUSY, bus.DTACK, bus.VPA, bus.BERR} !== V_IDLE) begin
      mismatched++;
      $display("FAIL reset_state: got vec=%b, want vec=%b",
               {bus.BUSY, bus.DTACK, bus.VPA, bus.BERR}, V_IDLE);
    end
    prev = V_IDLE;
    RST = 1'b1;
    mon_en = 1'b1;
    tick();

    // RAM, zero waits: DTACK at E0+1, release on AS high at E0+4.
    run_cycle(1, 0, 1, 1, -1, 4, V_DTACK, 1);   drain("ram");
    // ROM, two waits: DTACK at E0+3.
    run_cycle(0, 1, 1, 1, -1, 5, V_DTACK, 3);   drain("rom");
    // ROM ignores DTACK_MFP.
    run_cycle(0, 1, 1, 1, 1, 5, V_DTACK, 3);    drain("rom_ign_mfp");
    // ROM and RAM both selected: ROM priority.
    run_cycle(0, 0, 1, 1, -1, 5, V_DTACK, 3);   drain("rom_over_ram");
    // MFP acknowledges on edge 6.
    run_cycle(1, 1, 0, 1, 6, 9, V_DTACK, 6);    drain("mfp");
    // MFP over ROM priority.
    run_cycle(0, 1, 0, 1, 2, 5, V_DTACK, 2);    drain("mfp_over_rom");
    // MFP never acknowledges: BERR at E0+64.
    run_cycle(1, 1, 0, 1, -1, 66, V_BERR, 64);  drain("mfp_timeout");
    // IACK vectored by MFP on edge 4.
    run_cycle(1, 1, 0, 0, 4, 6, V_DTACK, 4);    drain("iack_vec");
    // IACK unvectored: VPA at E0+16, held past the timeout with no BERR.
    run_cycle(1, 1, 0, 0, -1, 70, V_VPA, 16);   drain("iack_avec");
    // Unmapped: BERR at E0+64.
    run_cycle(1, 1, 1, 1, -1, 66, V_BERR, 64);  drain("unmapped");
    // Unmapped aborted at edge 10: no response.
    run_cycle(1, 1, 1, 1, -1, 10, V_IDLE, -1);  drain("abort");
    // Back-to-back ROM then RAM, one idle edge between.
    run_cycle(0, 1, 1, 1, -1, 4, V_DTACK, 3);
    run_cycle(1, 0, 1, 1, -1, 3, V_DTACK, 1);   drain("b2b");

    // Reset during ACK releases everything on that edge.
    e0 = cyc + 1;
    bus.AS = 1'b0;
    bus.RAMEN = 1'b0;
    push(V_BUSY, e0);
    push(V_DTACK, e0 + 1);
    push(V_IDLE, e0 + 3);
    tick(); tick(); tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    bus.AS = 1'b1;
    bus.RAMEN = 1'b1;
    tick();
    drain("rst_in_ack");

    // Controller still works after the mid-cycle reset.
    run_cycle(1, 0, 1, 1, -1, 3, V_DTACK, 1);   drain("post_rst");
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end
endmodule
